// File: rtl/cmd_link_pkg.sv
// Shared definitions for the token-dispenser serial link (host side).
// Holds the link byte constants, the command status codes, the host FSM
// state encoding and the reply-sequence lookup used by the host FSM.
package cmd_link_pkg;

  localparam logic [7:0] ANNOUNCE = 8'h01;
  localparam logic [7:0] PING     = 8'h02;
  localparam logic [7:0] GO       = 8'h06;
  localparam logic [7:0] ACK      = 8'h04;
  localparam logic [7:0] PONG     = 8'h05;
  localparam logic [7:0] COMPLETE = 8'h00;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_TIMEOUT     = 3'd1,
    ST_BAD_RESP    = 3'd2,
    ST_NAK         = 3'd3,
    ST_SLAVE_RESET = 3'd4
  } status_e;

  typedef enum logic [2:0] {
    LINK_DOWN = 3'd0,
    READY     = 3'd1,
    SEND      = 3'd2,
    TXWAIT    = 3'd3,
    RESP      = 3'd4,
    DONE      = 3'd5
  } state_e;

  // Only PING and GO are understood by the dispenser; anything else makes it
  // reset and re-announce.
  function automatic logic verb_known(input logic [7:0] verb);
    return (verb == PING) || (verb == GO);
  endfunction

  // Expected reply byte at position idx of the reply sequence for verb.
  function automatic logic [7:0] expected_byte(input logic [7:0] verb,
                                               input logic [1:0] idx);
    logic [7:0] b;
    b = ANNOUNCE;
    if (verb == PING) begin
      b = PONG;
    end else if (verb == GO) begin
      case (idx)
        2'd0:    b = ACK;
        2'd1:    b = GO;
        default: b = COMPLETE;
      endcase
    end
    return b;
  endfunction

  // Index of the final reply byte for verb.
  function automatic logic [1:0] last_idx(input logic [7:0] verb);
    return (verb == GO) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// 32-bit loadable down-counter used as the reply timeout timer.
// Ports: clk/rst (async, active-high), load + load_val reload the count,
// en decrements it, expired is high while the count is zero.
// The count saturates at zero instead of wrapping.
module cmd_timeout_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  assign expired = (count == 32'd0);

endmodule

// File: rtl/cmd_host_fsm.sv
// Host-side command initiator for the token-dispenser serial link.
// Waits for the dispenser announce byte, sends one 4-byte command per
// cmd_valid/cmd_ready handshake through the async_transmitter byte
// interface, then checks the reply sequence and reports a status.
// Ports: clk50m/reset (async, active-high); cmd_* command handshake and
// bytes; tx_start/tx_data/tx_busy transmitter interface; rx_valid/rx_data
// receiver interface; link_up, done, status, last_rx result outputs.
module cmd_host_fsm
  import cmd_link_pkg::*;
#(
  parameter logic [31:0] RESP_TIMEOUT = 32'd5_000_000,
  parameter logic [31:0] DISP_TIMEOUT = 32'd500_000_000
) (
  input  logic       clk50m,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_verb,
  input  logic [7:0] cmd_arg1,
  input  logic [7:0] cmd_arg2,
  input  logic [7:0] cmd_arg3,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       link_up,
  output logic       done,
  output logic [2:0] status,
  output logic [7:0] last_rx
);

  state_e     state;
  logic [7:0] cmd_b [4];
  logic [1:0] idx;
  logic [1:0] ridx;
  logic       abort;
  logic       guard;

  logic        rx_ann;
  logic        tx_last;
  logic        rx_match;
  logic        rx_final;
  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_expired;
  logic [1:0]  ridx_next;
  logic [31:0] tmr_val;

  always_comb begin
    rx_ann    = rx_valid && (rx_data == ANNOUNCE);
    tx_last   = (state == TXWAIT) && !tx_busy && !guard && (idx == 2'd3);
    rx_match  = (state == RESP) && rx_valid &&
                (rx_data == expected_byte(cmd_b[0], ridx));
    rx_final  = (ridx == last_idx(cmd_b[0]));
    ridx_next = tx_last ? 2'd0 : ridx + 2'd1;
    // Only the GO completion byte waits for the physical dispense.
    tmr_val   = ((cmd_b[0] == GO) && (ridx_next == 2'd2)) ? DISP_TIMEOUT
                                                          : RESP_TIMEOUT;
    tmr_load  = tx_last || (rx_match && !rx_final);
    tmr_en    = (state == RESP);
  end

  cmd_timeout_ctr u_timer (
    .clk      (clk50m),
    .rst      (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Command bytes are pure data and need no reset.
  always_ff @(posedge clk50m) begin
    if ((state == READY) && cmd_valid) begin
      cmd_b[0] <= cmd_verb;
      cmd_b[1] <= cmd_arg1;
      cmd_b[2] <= cmd_arg2;
      cmd_b[3] <= cmd_arg3;
    end
  end

  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) begin
      state     <= LINK_DOWN;
      cmd_ready <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      link_up   <= 1'b0;
      done      <= 1'b0;
      status    <= ST_OK;
      last_rx   <= 8'h00;
      idx       <= 2'd0;
      ridx      <= 2'd0;
      abort     <= 1'b0;
      guard     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        LINK_DOWN: begin
          if (rx_ann) begin
            link_up   <= 1'b1;
            cmd_ready <= 1'b1;
            state     <= READY;
          end
        end
        READY: begin
          // tx_start is raised on entry to SEND so it is high exactly while
          // in SEND, one cycle after the accept.
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            idx       <= 2'd0;
            abort     <= 1'b0;
            tx_start  <= 1'b1;
            tx_data   <= cmd_verb;
            state     <= SEND;
          end
        end
        SEND: begin
          if (rx_ann) abort <= 1'b1;
          // The transmitter may not show busy until a cycle after start.
          guard <= 1'b1;
          state <= TXWAIT;
        end
        TXWAIT: begin
          guard <= 1'b0;
          if (rx_ann) abort <= 1'b1;
          if (!tx_busy && !guard) begin
            if (idx != 2'd3) begin
              idx      <= idx + 2'd1;
              tx_start <= 1'b1;
              tx_data  <= cmd_b[idx + 2'd1];
              state    <= SEND;
            end else if (abort || rx_ann) begin
              status <= ST_SLAVE_RESET;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              ridx  <= 2'd0;
              state <= RESP;
            end
          end
        end
        RESP: begin
          // A received byte takes precedence over a same-cycle expiry.
          if (rx_valid) begin
            last_rx <= rx_data;
            if (rx_match && rx_final) begin
              status <= verb_known(cmd_b[0]) ? ST_OK : ST_NAK;
              done   <= 1'b1;
              state  <= DONE;
            end else if (rx_match) begin
              ridx <= ridx + 2'd1;
            end else if (rx_data == ANNOUNCE) begin
              status <= ST_SLAVE_RESET;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              status <= ST_BAD_RESP;
              done   <= 1'b1;
              state  <= DONE;
            end
          end else if (tmr_expired) begin
            status  <= ST_TIMEOUT;
            link_up <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (status == ST_TIMEOUT) begin
            state <= LINK_DOWN;
          end else begin
            cmd_ready <= 1'b1;
            state     <= READY;
          end
        end
        default: state <= LINK_DOWN;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_host_fsm.sv
module tb_cmd_host_fsm;

  logic       clk50m = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_verb, cmd_arg1, cmd_arg2, cmd_arg3;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       link_up;
  logic       done;
  logic [2:0] status;
  logic [7:0] last_rx;

  int checks = 0;
  int errors = 0;

  logic [7:0] txq[$];
  int         busy_cnt = 0;
  logic       prev_start = 1'b0;

  cmd_host_fsm #(
    .RESP_TIMEOUT (32'd200),
    .DISP_TIMEOUT (32'd1000)
  ) dut (
    .clk50m    (clk50m),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_verb  (cmd_verb),
    .cmd_arg1  (cmd_arg1),
    .cmd_arg2  (cmd_arg2),
    .cmd_arg3  (cmd_arg3),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .link_up   (link_up),
    .done      (done),
    .status    (status),
    .last_rx   (last_rx)
  );

  always #5 clk50m = ~clk50m;

  // Transmitter model: busy for 10 cycles after each start pulse.
  always @(posedge clk50m) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every tx_start pops the next expected byte.
  always @(negedge clk50m) begin
    if (!reset && tx_start) begin
      chk("tx_start_width", {31'd0, prev_start}, 32'd0);
      chk("tx_while_busy", {31'd0, tx_busy}, 32'd0);
      if (txq.size() == 0) begin
        chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
      end
    end
    prev_start <= tx_start;
  end

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk50m);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk50m);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] v, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3);
    txq.push_back(v);
    txq.push_back(a1);
    txq.push_back(a2);
    txq.push_back(a3);
    @(negedge clk50m);
    cmd_valid = 1'b1;
    cmd_verb = v; cmd_arg1 = a1; cmd_arg2 = a2; cmd_arg3 = a3;
    @(negedge clk50m);
    cmd_valid = 1'b0;
    chk("accept_latency", {31'd0, tx_start}, 32'd1);
    chk("ready_drop", {31'd0, cmd_ready}, 32'd0);
  endtask

  // Wait until all bytes are out and the transmitter has gone idle.
  task automatic drain(input string tag);
    int n = 0;
    while (txq.size() != 0 && n < 400) begin
      @(negedge clk50m);
      n++;
    end
    chk({tag, "_drain"}, txq.size(), 32'd0);
    repeat (15) @(negedge clk50m);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk50m);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_verb = 8'h00; cmd_arg1 = 8'h00; cmd_arg2 = 8'h00; cmd_arg3 = 8'h00;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk50m);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_link_up", {31'd0, link_up}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_status", {29'd0, status}, 32'd0);
    reset = 1'b0;

    // Boot
    rx_byte(8'h07);
    chk("boot_ignore_link", {31'd0, link_up}, 32'd0);
    chk("boot_ignore_ready", {31'd0, cmd_ready}, 32'd0);
    rx_byte(8'h01);
    chk("boot_link_up", {31'd0, link_up}, 32'd1);
    chk("boot_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Ping
    send_cmd(8'h02, 8'h00, 8'h00, 8'h00);
    drain("ping");
    rx_byte(8'h05);
    wait_done("ping", 10);
    chk("ping_status", {29'd0, status}, 32'd0);
    chk("ping_last_rx", {24'd0, last_rx}, 32'h05);
    @(negedge clk50m);
    chk("ping_done_pulse", {31'd0, done}, 32'd0);
    chk("ping_ready", {31'd0, cmd_ready}, 32'd1);

    // Go dispense, completion well past the ordinary reply timeout
    send_cmd(8'h06, 8'h03, 8'h01, 8'h02);
    drain("go");
    rx_byte(8'h04);
    repeat (3) @(negedge clk50m);
    rx_byte(8'h06);
    repeat (600) @(negedge clk50m);
    chk("go_still_waiting", {31'd0, link_up}, 32'd1);
    rx_byte(8'h00);
    wait_done("go", 10);
    chk("go_status", {29'd0, status}, 32'd0);
    chk("go_last_rx", {24'd0, last_rx}, 32'h00);

    // Go with no completion byte
    @(negedge clk50m);
    send_cmd(8'h06, 8'h01, 8'h01, 8'h01);
    drain("go_to");
    rx_byte(8'h04);
    rx_byte(8'h06);
    wait_done("go_to", 1500);
    chk("go_to_status", {29'd0, status}, 32'd1);
    chk("go_to_link", {31'd0, link_up}, 32'd0);
    @(negedge clk50m);
    chk("go_to_not_ready", {31'd0, cmd_ready}, 32'd0);
    rx_byte(8'h01);
    chk("relink_ready", {31'd0, cmd_ready}, 32'd1);

    // Unknown verb: dispenser re-announces
    send_cmd(8'h09, 8'h01, 8'h02, 8'h03);
    drain("nak");
    rx_byte(8'h01);
    wait_done("nak", 10);
    chk("nak_status", {29'd0, status}, 32'd3);
    chk("nak_link", {31'd0, link_up}, 32'd1);

    // Wrong reply to ping
    @(negedge clk50m);
    send_cmd(8'h02, 8'h00, 8'h00, 8'h00);
    drain("bad");
    rx_byte(8'h04);
    wait_done("bad", 10);
    chk("bad_status", {29'd0, status}, 32'd2);
    chk("bad_last_rx", {24'd0, last_rx}, 32'h04);

    // Announce while the 2nd byte is in flight
    @(negedge clk50m);
    send_cmd(8'h06, 8'h02, 8'h02, 8'h02);
    begin
      int n = 0;
      while (txq.size() > 2 && n < 100) begin
        @(negedge clk50m);
        n++;
      end
      chk("sr_second_byte", txq.size(), 32'd2);
    end
    rx_byte(8'h01);
    wait_done("sr", 200);
    chk("sr_status", {29'd0, status}, 32'd4);
    chk("sr_all_sent", txq.size(), 32'd0);
    chk("sr_link", {31'd0, link_up}, 32'd1);

    // Reset during TXWAIT
    @(negedge clk50m);
    send_cmd(8'h02, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk50m);
    #2 reset = 1'b1;
    #1;
    chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("arst_link_up", {31'd0, link_up}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_status", {29'd0, status}, 32'd0);
    chk("arst_last_rx", {24'd0, last_rx}, 32'd0);
    txq.delete();
    repeat (2) @(negedge clk50m);
    reset = 1'b0;
    repeat (15) @(negedge clk50m);
    chk("arst_needs_announce", {31'd0, cmd_ready}, 32'd0);
    rx_byte(8'h01);
    chk("arst_relink", {31'd0, cmd_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
